sync_fifo: RTL
==============

Name: sync_fifo

Overview:
- Single-clock, first-word-fall-through FIFO.
- Pairs a writer (write_en/in) with a reader (read_en/out) across a bounded queue of DEPTH entries.
- Used as the buffering primitive between pipeline stages whose producer and consumer issue at different times.
- Provides full/empty/count status and single-cycle error pulses for illegal accesses.

Parameters:
- WIDTH, 32, data width in bits.
- DEPTH, 4, number of entries; must be a power of 2 and >= 2.
- SAFE, 0, when 0 storage and out-when-empty are don't-care ('x); when 1, storage resets to 0 and out is 0 while empty.

Ports:
- clk  input  1  clock; all state updates on posedge.
- reset  input  1  reset: synchronous, active-high; clock clk.
- write_en  input  1  push request for the current cycle.
- in  input  WIDTH  push data, sampled when a push is accepted.
- read_en  input  1  pop request for the current cycle.
- out  output  WIDTH  head entry, combinational from storage (FWFT).
- empty  output  1  count == 0.
- full  output  1  count == DEPTH.
- count  output  $clog2(DEPTH)+1  number of valid entries, 0..DEPTH.
- overflow  output  1  registered one-cycle pulse: rejected push.
- underflow  output  1  registered one-cycle pulse: rejected pop.

Behaviour:
- State:
  - wr_ptr and rd_ptr, each $clog2(DEPTH) bits, wrapping modulo DEPTH.
  - count register.
  - DEPTH x WIDTH storage array.
- Reset:
  - wr_ptr = rd_ptr = 0, count = 0, empty = 1, full = 0, overflow = underflow = 0.
  - Storage = 0 when SAFE = 1; storage untouched when SAFE = 0.
  - Reset takes priority over all other inputs in the same cycle.
  - Reset mid-operation discards all contents.
- Accept rules, evaluated on pre-edge state:
  - pop_ok = read_en && !empty.
  - push_ok = write_en && (!full || pop_ok).
- On push_ok: mem[wr_ptr] <= in; wr_ptr increments.
- On pop_ok: rd_ptr increments.
- count update:
  - +1 on push only.
  - -1 on pop only.
  - Unchanged on both or neither.
- Full with simultaneous push and pop: both accepted; count stays DEPTH; full stays 1.
- Empty with simultaneous push and pop: pop rejected (no bypass), push accepted; count becomes 1; underflow pulses.
- out:
  - Equals mem[rd_ptr] whenever !empty.
  - A pushed value appears on out the cycle after the push that made the FIFO non-empty (1-cycle latency, no combinational in->out path).
  - When empty: '0 if SAFE = 1, otherwise don't-care.
- Error pulses:
  - overflow <= write_en && !push_ok.
  - underflow <= read_en && !pop_ok.
  - Each is high for exactly the cycle after the offending request.
  - A rejected request changes no other state.
- Wrap-around: pointers roll from DEPTH-1 to 0; full/empty are derived from count, not from pointer equality.
- Status outputs empty, full and count are registered or derived from registered count only; they never depend on same-cycle inputs.

Test Plan:
- Fill/order check (DEPTH=4, WIDTH=32):
  - Stimulus: reset, then push 0x11, 0x22, 0x33, 0x44 on consecutive cycles, then pop 4 times.
  - Required: full=1 and count=4 after the 4th push; out shows 0x11, 0x22, 0x33, 0x44 in order; empty=1 and count=0 at the end.
- Overflow:
  - Stimulus: with the FIFO full, push 0x55 without read_en.
  - Required: overflow=1 for one cycle; count stays 4; subsequent pops still return 0x11..0x44.
- Full simultaneous push and pop:
  - Stimulus: with the FIFO full, push 0xAA and pop in the same cycle.
  - Required: count=4; out advances to 0x22; 0xAA emerges as the 4th subsequent pop.
- Empty simultaneous push and pop:
  - Stimulus: with the FIFO empty, push 0x77 and pop in the same cycle.
  - Required: underflow=1; count=1; out=0x77 next cycle.
- Wrap-around:
  - Stimulus: 10 interleaved push/pop pairs with data 1..10.
  - Required: data returns in order 1..10 across pointer wrap; count never exceeds 1.
- Reset mid-operation:
  - Stimulus: push 3 entries, assert reset together with write_en.
  - Required: count=0, empty=1, no entry stored; with SAFE=1, out=0.

Source files
------------

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock first-word-fall-through FIFO.
//
// The head entry is always visible on `out` while the FIFO is non-empty, so a
// consumer can inspect data before deciding to pop. Status is derived solely
// from the registered occupancy count, never from same-cycle inputs.
//
// Ports:
//   clk        clock, all state updates on posedge
//   reset      synchronous, active-high; discards all contents
//   write_en   push request; `in` is captured when the push is accepted
//   in         push data
//   read_en    pop request
//   out        head entry (combinational from storage)
//   empty      count == 0
//   full       count == DEPTH
//   count      number of valid entries, 0..DEPTH
//   overflow   one-cycle pulse after a rejected push
//   underflow  one-cycle pulse after a rejected pop
//
// Parameters:
//   WIDTH  data width
//   DEPTH  entries, power of 2 and >= 2
//   SAFE   1: storage clears on reset and out is 0 while empty

module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  parameter bit SAFE  = 1'b0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       write_en,
  input  logic [WIDTH-1:0]           in,
  input  logic                       read_en,
  output logic [WIDTH-1:0]           out,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    cnt_q;

  logic pop_ok;
  logic push_ok;

  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == CNT_FULL);
  assign count = cnt_q;

  // A push into a full FIFO is legal only when a pop frees the slot in the
  // same cycle. No bypass when empty: the pop is rejected, the push lands.
  assign pop_ok  = read_en && !empty;
  assign push_ok = write_en && (!full || pop_ok);

  // Pointers wrap naturally because DEPTH is a power of 2.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      cnt_q     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_ONE;
      if (push_ok && !pop_ok)      cnt_q <= cnt_q + CNT_ONE;
      else if (pop_ok && !push_ok) cnt_q <= cnt_q - CNT_ONE;
      overflow  <= write_en && !push_ok;
      underflow <= read_en && !pop_ok;
    end
  end

  // Storage carries no reset unless SAFE is set, so it can map to plain RAM.
  always_ff @(posedge clk) begin
    if (reset) begin
      if (SAFE) begin
        for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end
    end else if (push_ok) begin
      mem[wr_ptr] <= in;
    end
  end

  assign out = (SAFE && empty) ? '0 : mem[rd_ptr];

endmodule
